// File: rtl/button_counter_ctrl.sv
// Debounced two-button controller driving a 4-bit LED counter.
// Define BUTTON_COUNTER_AUTOREPEAT_EN to enable auto-repeat on the increment button.
module button_counter_ctrl #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = 17,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pmod,
  output logic [3:0] led
);

  localparam logic [1:0] S_REL     = 2'd0;
  localparam logic [1:0] S_PWAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED = 2'd2;
  localparam logic [1:0] S_RWAIT   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]            sync1_q;
  logic [1:0]            sync2_q;
  logic [1:0][1:0]       st_q;
  logic [1:0][1:0]       st_d;
  logic [1:0][CNT_W-1:0] cnt_q;
  logic [1:0][CNT_W-1:0] cnt_d;
  logic [1:0]            press;
  logic [3:0]            led_q;
  logic [3:0]            led_d;
  logic                  inc_pulse;
  logic                  clr_pulse;

  // sync2_q is the level seen by the FSMs; 0 means pressed
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      press[i] = 1'b0;
      unique case (st_q[i])
        S_REL: begin
          if (!sync2_q[i]) begin
            cnt_d[i] = '0;
            st_d[i]  = S_PWAIT;
          end
        end
        S_PWAIT: begin
          if (sync2_q[i]) begin
            st_d[i] = S_REL;
          end else if (cnt_q[i] == CNT_LAST) begin
            st_d[i]  = S_PRESSED;
            press[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        S_PRESSED: begin
          if (sync2_q[i]) begin
            cnt_d[i] = '0;
            st_d[i]  = S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (!sync2_q[i]) begin
            st_d[i] = S_PRESSED;
          end else if (cnt_q[i] == CNT_LAST) begin
            st_d[i] = S_REL;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: st_d[i] = S_REL;
      endcase
    end
  end

`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  logic [RW-1:0] hold_q;
  logic [RW-1:0] hold_d;
  logic          rep;

  // after the first repeat, rewind so the next match is one period away
  always_comb begin
    hold_d = '0;
    rep    = 1'b0;
    if (st_q[1] == S_PRESSED && !sync2_q[1]) begin
      if (hold_q == RW'(REPEAT_DELAY - 1)) begin
        rep    = 1'b1;
        hold_d = RW'(REPEAT_DELAY - REPEAT_PERIOD);
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  assign inc_pulse = press[1] | rep;
`else
  assign inc_pulse = press[1];
`endif

  assign clr_pulse = press[0];

  always_comb begin
    led_d = led_q;
    if (clr_pulse)      led_d = 4'd0;
    else if (inc_pulse) led_d = led_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      st_q    <= {S_REL, S_REL};
      cnt_q   <= '0;
      led_q   <= 4'd0;
    end else begin
      sync1_q <= pmod;
      sync2_q <= sync1_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_button_counter_ctrl.sv
// Bench for button_counter_ctrl: directed steps plus random button
// activity, compared every cycle against a run-length debounce model.
module tb_button_counter_ctrl;

  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RP  = 5;
`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pmod;
  logic [3:0] led;

  int errs   = 0;
  int checks = 0;

  int mled;
  bit db  [2];
  int run [2];
  bit p1  [2];
  bit p2  [2];
  int hold;

  button_counter_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(3),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pmod(pmod),
    .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: led=%0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mled = 0;
    hold = 0;
    for (int i = 0; i < 2; i++) begin
      db[i]  = 1'b0;
      run[i] = 0;
      p1[i]  = 1'b1;
      p2[i]  = 1'b1;
    end
  endtask

  // A button's accepted state flips after DB+1 consecutive synchronised
  // samples that disagree with it; a flip to pressed is one command.
  task automatic model_edge(input logic [1:0] v);
    bit ev [2];
    bit pr;
    bit steady;
    bit rep;
    rep = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pr = !p2[i];
      p2[i] = p1[i];
      p1[i] = v[i];
      ev[i] = 1'b0;
      steady = db[i] && run[i] == 0;
      if (i == 1) begin
        if (steady && pr) begin
          hold++;
          if (AR && hold >= RD && (hold - RD) % RP == 0) rep = 1'b1;
        end else begin
          hold = 0;
        end
      end
      if (pr != db[i]) run[i]++;
      else             run[i] = 0;
      if (run[i] == DB + 1) begin
        db[i]  = pr;
        run[i] = 0;
        ev[i]  = pr;
      end
    end
    if (ev[0])              mled = 0;
    else if (ev[1] || rep)  mled = (mled + 1) % 16;
  endtask

  task automatic cyc(input logic [1:0] v);
    pmod = v;
    @(posedge clk);
    model_edge(v);
    #1 chk("cycle", led, 4'(mled));
    @(negedge clk);
  endtask

  task automatic press(input logic [1:0] v, input int lo, input int hi);
    repeat (lo) cyc(v);
    repeat (hi) cyc(2'b11);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst", led, 4'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] rv;
    rst  = 1'b1;
    pmod = 2'b11;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset", led, 4'd0);
    rst = 1'b0;

    repeat (50) cyc(2'b11);
    chk("idle", led, 4'd0);

    for (int k = 1; k <= 20; k++) begin
      cyc(2'b01);
      if (k == 6) chk("lat_before", led, 4'd0);
      if (k == 7) chk("lat_edge", led, 4'd1);
    end
    repeat (10) cyc(2'b11);
    chk("after_release", led, 4'd1);

    pulse_rst();

    repeat (3) cyc(2'b01);
    cyc(2'b11);
    repeat (3) cyc(2'b01);
    repeat (8) cyc(2'b11);
    chk("bounce", led, 4'd0);
    press(2'b01, 8, 8);
    chk("post_bounce", led, 4'd1);

    press(2'b10, 8, 8);
    chk("clear", led, 4'd0);
    for (int i = 0; i < 17; i++) begin
      press(2'b01, 8, 8);
      chk("wrap", led, 4'((i + 1) % 16));
    end

    press(2'b10, 8, 8);
    repeat (5) press(2'b01, 8, 8);
    chk("preload", led, 4'd5);
    press(2'b00, 8, 8);
    chk("clr_wins", led, 4'd0);
    press(2'b01, 8, 8);
    chk("after_clr", led, 4'd1);

    repeat (3) cyc(2'b01);
    pulse_rst();
    repeat (20) cyc(2'b01);
    repeat (8) cyc(2'b11);
    chk("held_thru_rst", led, 4'd1);

    press(2'b10, 8, 8);
    for (int k = 1; k <= 47; k++) begin
      cyc(2'b01);
      if (k == 26) chk("rep_before", led, 4'd1);
      if (k == 27) chk("rep_first", led, AR ? 4'd2 : 4'd1);
    end
    repeat (10) cyc(2'b11);
    chk("rep_total", led, AR ? 4'd6 : 4'd1);

    for (int n = 0; n < 60; n++) begin
      rv = 2'($urandom_range(0, 3));
      if (rv == 2'b10 && $urandom_range(0, 3) != 0) rv = 2'b01;
      repeat ($urandom_range(1, 12)) cyc(rv);
    end
    repeat (12) cyc(2'b11);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/button_counter_ctrl.md
Name: button_counter_ctrl

Overview:
Controller that sequences the 4-bit LED counter from the two PMOD push-buttons on a free-running board clock.
- Synchronises and debounces both active-low buttons.
- Converts each clean press into a single-cycle command: pmod[1] increments, pmod[0] clears.
- Applies the commands to the LED count register.
- Replaces the direct button-as-clock / button-as-reset scheme; the count becomes a fully synchronous datapath.

Parameters:
DEBOUNCE_CYCLES, 120000, consecutive stable cycles before a button change is accepted (10 ms at 12 MHz); legal range ≥2.
CNT_W, 17, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REPEAT_DELAY, 6000000, hold time in cycles before auto-repeat starts (AUTOREPEAT_EN only).
REPEAT_PERIOD, 1200000, cycles between auto-repeat increments (AUTOREPEAT_EN only).

Ports:
clk  input  1  board clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
pmod  input  2  raw buttons, active-low; [0]=clear, [1]=increment; asynchronous to clk
led  output  4  current count

Behaviour:
- Reset (rst=1, asynchronous), state held while rst high:
  - sync flops=1 (released); debounced state=released; debounce counters=0.
  - Both FSMs in RELEASED; command pulses=0; led=4'b0000.
- Synchroniser: each pmod bit passes through a 2-flop chain before any other use.
- Per-button FSM, driven by the synchronised level s (pressed = s==0):
  - RELEASED: if pressed, counter<=0, go PRESS_WAIT.
  - PRESS_WAIT: if released, go RELEASED (bounce rejected, no command). Else counter increments; when counter==DEBOUNCE_CYCLES-1, go PRESSED and assert the press pulse for exactly one cycle.
  - PRESSED: if released, counter<=0, go RELEASE_WAIT.
  - RELEASE_WAIT: if pressed, go PRESSED (no new pulse). Else count; at DEBOUNCE_CYCLES-1 go RELEASED.
- Latency: a clean pmod falling edge changes led on exactly the (DEBOUNCE_CYCLES+3)th rising clk edge after the edge is first sampled. No further effect while held.
- Count datapath (registered):
  - clr_pulse=1 → led<=0.
  - else inc_pulse=1 → led<=led+1, modulo 16 (4'b1111 wraps to 4'b0000, no flag).
  - else hold.
- Simultaneous events: clear and increment pulses in the same cycle → clear wins; the increment is discarded, not deferred.
- A release never generates a command. A press shorter than DEBOUNCE_CYCLES cycles generates nothing.
- Reset mid-operation: any in-flight debounce is abandoned. After rst falls, a button already held low must pass a full PRESS_WAIT before its command fires (exactly one command).
- Buttons operate independently: holding clear does not block increment debouncing, but every increment pulse is overridden while a clear pulse is present.

Optional Feature:
Macro: BUTTON_COUNTER_AUTOREPEAT_EN.
- Defined:
  - Increment FSM gains a hold timer that starts on entry to PRESSED.
  - After REPEAT_DELAY cycles in PRESSED, an extra inc pulse fires; further pulses follow every REPEAT_PERIOD cycles until the FSM leaves PRESSED.
  - Timer zeroed on leaving PRESSED and on rst. Clear button never repeats.
  - Clear-wins priority still applies.
- Undefined: no hold timer logic is generated; exactly one increment per press regardless of hold duration.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5 for simulation):
1. Reset, then pmod=2'b11 for 50 cycles → led stays 0; assert rst mid-run → led=0 immediately, before any clk edge.
2. Clean press of pmod[1] held 20 cycles → led=1 exactly 7 edges after the first sampling edge; led stays 1 while held and after release.
3. pmod[1] bounce: low 3 cycles, high 1, low 3, high → led unchanged at 0; then a clean press → led=1 (single count).
4. 17 clean presses of pmod[1] from led=0 → led steps 1..15, 0, 1; wrap causes no glitch.
5. Preload led=5, then press pmod[0] and pmod[1] on the same cycle → led=0 at the pulse edge, not 1; next clean pmod[1] press → led=1.
6. With BUTTON_COUNTER_AUTOREPEAT_EN: hold pmod[1] for 40 cycles past its press pulse → led=1 at the press, 2 at +20 cycles, 3 at +25, and so on (1 + count of repeats). Without the macro, same stimulus → led=1 only.
